// File: rtl/column_approx_pkg.sv
// Shared types and helpers for the column-truncated sequential multiplier.
// Optional COLUMN_APPROX_COMP_EN adds a rounding constant to approximate results.
package column_approx_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Bit j of the result is set when x[j] of the given row lands at or above the truncation column.
  function automatic logic [31:0] row_keep_mask(input int width, input int theta, input int row);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 32; j++)
      m[j] = (j < width) && (row + j >= theta);
    return m;
  endfunction

endpackage

// File: rtl/column_approx_row.sv
// One partial-product row: x gated by the multiplier bit, truncated columns masked, shifted into place.
module column_approx_row
  import column_approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int THETA = 9,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   x,
  input  logic               y_bit,
  input  logic [CW-1:0]      row,
  input  logic               approx_en,
  output logic [2*WIDTH-1:0] row_val
);

  logic [WIDTH-1:0] keep;

  always_comb begin
    keep = '1;
    if (approx_en)
      for (int j = 0; j < WIDTH; j++)
        keep[j] = |(row_keep_mask(WIDTH, THETA, int'(row)) & (32'd1 << j));
  end

  assign row_val = (2*WIDTH)'(x & keep & {WIDTH{y_bit}}) << row;

endmodule

// File: rtl/column_approx_seq.sv
// Sequential shift-add multiplier with optional low-column truncation, one row per cycle.
// Build macro COLUMN_APPROX_COMP_EN adds 2^(THETA-1) to truncated results.
module column_approx_seq
  import column_approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int THETA = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     xr, yr;
  logic                 aer;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, row_val, sum, fin;

  column_approx_row #(.WIDTH(WIDTH), .THETA(THETA), .CW(CW)) u_row (
    .x        (xr),
    .y_bit    (yr[cnt]),
    .row      (cnt),
    .approx_en(aer),
    .row_val  (row_val)
  );

  assign sum = acc + row_val;

`ifdef COLUMN_APPROX_COMP_EN
  localparam logic [2*WIDTH-1:0] COMP =
    (THETA >= 1) ? ((2*WIDTH)'(1) << ((THETA >= 1) ? THETA - 1 : 0)) : '0;
  assign fin = sum + (aer ? COMP : '0);
`else
  assign fin = sum;
`endif

  // in_ready and busy are registered so both read 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      aer       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xr       <= x;
            yr       <= y;
            aer      <= approx_en;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            z         <= fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            z         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
